video_crtc_timing: RTL and testbench

Character-clock timing generator for the EconoPET's MC6845/6545-compatible CRTC. It consumes the decoded CRTC register values (R0–R9, R12/R13) produced by the CRTC register block and produces HSYNC, VSYNC, display enable, refresh memory address (MA) and row address (RA) for the video fetch and pixel path. Counters advance once per character, gated by `clk_en_i`.

---
 rtl/video_crtc_timing.sv | 179 +++++++++++++++++
 tb/tb_video_crtc_timing.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_crtc_timing.sv
// MC6845/6545-compatible CRTC character-clock timing generator: turns decoded
// CRTC register values into HSYNC/VSYNC, display enable, refresh address and row address.
module video_crtc_timing (
  input  logic        sys_clock_i,
  input  logic        reset_n_i,
  input  logic        clk_en_i,
  input  logic [7:0]  r0_h_total_i,
  input  logic [7:0]  r1_h_displayed_i,
  input  logic [7:0]  r2_h_sync_pos_i,
  input  logic [3:0]  r3_h_sync_width_i,
  input  logic [4:0]  r3_v_sync_width_i,
  input  logic [6:0]  r4_v_total_i,
  input  logic [4:0]  r5_v_adjust_i,
  input  logic [6:0]  r6_v_displayed_i,
  input  logic [6:0]  r7_v_sync_pos_i,
  input  logic [4:0]  r9_max_scan_line_i,
  input  logic [13:0] r1213_start_addr_i,
  output logic        h_sync_o,
  output logic        v_sync_o,
  output logic        de_o,
  output logic [13:0] ma_o,
  output logic [4:0]  ra_o,
  output logic        frame_start_o
);

  typedef enum logic {
    ROWS   = 1'b0,
    ADJUST = 1'b1
  } vstate_e;

  logic [7:0]  h_q, h_d;
  logic [4:0]  ra_q, ra_d;
  logic [6:0]  row_q, row_d;
  vstate_e     vstate_q, vstate_d;
  logic [3:0]  hsw_cnt_q, hsw_cnt_d;
  logic [4:0]  vsw_cnt_q, vsw_cnt_d;
  logic [13:0] ma_q, ma_d;
  logic [13:0] row_ma_q, row_ma_d;
  logic        first_q, first_d;
  logic        h_sync_q, h_sync_d;
  logic        v_sync_q, v_sync_d;
  logic        de_q, de_d;
  logic        frame_start_q, frame_start_d;

  logic        eol;
  logic        new_frame;
  logic        line_start;
  logic [4:0]  ra_inc;

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path through
    // the conditionals below leaves it unassigned, which would infer a latch.
    h_d           = h_q;
    ra_d          = ra_q;
    row_d         = row_q;
    vstate_d      = vstate_q;
    hsw_cnt_d     = hsw_cnt_q;
    vsw_cnt_d     = vsw_cnt_q;
    ma_d          = ma_q;
    row_ma_d      = row_ma_q;
    first_d       = first_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    de_d          = de_q;
    frame_start_d = frame_start_q;
    eol           = (h_q >= r0_h_total_i);
    new_frame     = 1'b0;
    line_start    = 1'b0;
    ra_inc        = ra_q + 5'd1;

    if (clk_en_i) begin
      first_d = 1'b0;

      // Character r1 of the last scan line is where the next row begins.
      if (h_q == r1_h_displayed_i && vstate_q == ROWS && ra_q >= r9_max_scan_line_i) begin
        row_ma_d = ma_q;
      end

      if (first_q) begin
        new_frame = 1'b1;
      end else if (!eol) begin
        h_d  = h_q + 8'd1;
        ma_d = ma_q + 14'd1;
      end else begin
        h_d        = 8'd0;
        line_start = 1'b1;
        if (vstate_q == ROWS) begin
          if (ra_q >= r9_max_scan_line_i) begin
            ra_d  = 5'd0;
            row_d = row_q + 7'd1;
            if (row_q >= r4_v_total_i) begin
              if (r5_v_adjust_i == 5'd0) new_frame = 1'b1;
              else                       vstate_d  = ADJUST;
            end
          end else begin
            ra_d = ra_inc;
          end
        end else begin
          ra_d = ra_inc;
          if (ra_inc == r5_v_adjust_i) new_frame = 1'b1;
        end
        ma_d = row_ma_d;
      end

      // Start address is sampled only here; a mid-frame R12/13 write waits.
      if (new_frame) begin
        h_d        = 8'd0;
        ra_d       = 5'd0;
        row_d      = 7'd0;
        vstate_d   = ROWS;
        ma_d       = r1213_start_addr_i;
        row_ma_d   = r1213_start_addr_i;
        line_start = 1'b1;
      end

      if (h_d == r2_h_sync_pos_i && r3_h_sync_width_i != 4'd0) begin
        hsw_cnt_d = r3_h_sync_width_i;
      end else if (hsw_cnt_q != 4'd0) begin
        hsw_cnt_d = hsw_cnt_q - 4'd1;
      end

      if (line_start) begin
        if (vstate_d == ROWS && ra_d == 5'd0 && row_d == r7_v_sync_pos_i) begin
          vsw_cnt_d = r3_v_sync_width_i;
        end else if (vsw_cnt_q != 5'd0) begin
          vsw_cnt_d = vsw_cnt_q - 5'd1;
        end
      end

      h_sync_d      = (hsw_cnt_d != 4'd0);
      v_sync_d      = (vsw_cnt_d != 5'd0);
      de_d          = (h_d < r1_h_displayed_i) && (vstate_d == ROWS) &&
                      (row_d < r6_v_displayed_i);
      frame_start_d = new_frame;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      h_q           <= 8'd0;
      ra_q          <= 5'd0;
      row_q         <= 7'd0;
      vstate_q      <= ROWS;
      hsw_cnt_q     <= 4'd0;
      vsw_cnt_q     <= 5'd0;
      ma_q          <= 14'd0;
      row_ma_q      <= 14'd0;
      first_q       <= 1'b1;
      h_sync_q      <= 1'b0;
      v_sync_q      <= 1'b0;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      ra_q          <= ra_d;
      row_q         <= row_d;
      vstate_q      <= vstate_d;
      hsw_cnt_q     <= hsw_cnt_d;
      vsw_cnt_q     <= vsw_cnt_d;
      ma_q          <= ma_d;
      row_ma_q      <= row_ma_d;
      first_q       <= first_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_sync_o      = h_sync_q;
  assign v_sync_o      = v_sync_q;
  assign de_o          = de_q;
  assign ma_o          = ma_q;
  assign ra_o          = ra_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_video_crtc_timing.sv
// Self-checking bench for video_crtc_timing: per-character vectors on a small
// frame, whole-frame statistics for several register sets, plus corner sequences.
module tb_video_crtc_timing;

  typedef struct packed {
    logic [7:0]  r0, r1, r2;
    logic [3:0]  r3h;
    logic [4:0]  r3v;
    logic [6:0]  r4;
    logic [4:0]  r5;
    logic [6:0]  r6, r7;
    logic [4:0]  r9;
    logic [13:0] sa;
  } cfg_t;

  typedef struct {
    string name;
    cfg_t  cfg;
    int    len, de_n, hs_n, vs_n, vs_rise;
  } frame_vec_t;

  typedef struct packed {
    logic        fs, de, hs, vs;
    logic [13:0] ma;
    logic [4:0]  ra;
  } obs_t;

  logic        sys_clock_i = 1'b0;
  logic        reset_n_i   = 1'b0;
  logic        clk_en_i    = 1'b0;
  logic [7:0]  r0_h_total_i, r1_h_displayed_i, r2_h_sync_pos_i;
  logic [3:0]  r3_h_sync_width_i;
  logic [4:0]  r3_v_sync_width_i;
  logic [6:0]  r4_v_total_i;
  logic [4:0]  r5_v_adjust_i;
  logic [6:0]  r6_v_displayed_i, r7_v_sync_pos_i;
  logic [4:0]  r9_max_scan_line_i;
  logic [13:0] r1213_start_addr_i;
  logic        h_sync_o, v_sync_o, de_o, frame_start_o;
  logic [13:0] ma_o;
  logic [4:0]  ra_o;

  int tests_run    = 0;
  int tests_failed = 0;

  video_crtc_timing dut (
    .sys_clock_i        (sys_clock_i),
    .reset_n_i          (reset_n_i),
    .clk_en_i           (clk_en_i),
    .r0_h_total_i       (r0_h_total_i),
    .r1_h_displayed_i   (r1_h_displayed_i),
    .r2_h_sync_pos_i    (r2_h_sync_pos_i),
    .r3_h_sync_width_i  (r3_h_sync_width_i),
    .r3_v_sync_width_i  (r3_v_sync_width_i),
    .r4_v_total_i       (r4_v_total_i),
    .r5_v_adjust_i      (r5_v_adjust_i),
    .r6_v_displayed_i   (r6_v_displayed_i),
    .r7_v_sync_pos_i    (r7_v_sync_pos_i),
    .r9_max_scan_line_i (r9_max_scan_line_i),
    .r1213_start_addr_i (r1213_start_addr_i),
    .h_sync_o           (h_sync_o),
    .v_sync_o           (v_sync_o),
    .de_o               (de_o),
    .ma_o               (ma_o),
    .ra_o               (ra_o),
    .frame_start_o      (frame_start_o)
  );

  always #5 sys_clock_i = ~sys_clock_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t observe();
    return '{frame_start_o, de_o, h_sync_o, v_sync_o, ma_o, ra_o};
  endfunction

  function automatic obs_t mk(input logic fs, input logic de, input logic hs, input logic vs,
                              input logic [13:0] ma, input logic [4:0] ra);
    return '{fs, de, hs, vs, ma, ra};
  endfunction

  task automatic tick();
    @(posedge sys_clock_i);
    #1;
  endtask

  task automatic apply_cfg(input cfg_t c);
    r0_h_total_i       = c.r0;
    r1_h_displayed_i   = c.r1;
    r2_h_sync_pos_i    = c.r2;
    r3_h_sync_width_i  = c.r3h;
    r3_v_sync_width_i  = c.r3v;
    r4_v_total_i       = c.r4;
    r5_v_adjust_i      = c.r5;
    r6_v_displayed_i   = c.r6;
    r7_v_sync_pos_i    = c.r7;
    r9_max_scan_line_i = c.r9;
    r1213_start_addr_i = c.sa;
  endtask

  // Leaves the DUT out of reset with clk_en_i=1; the next tick is the frame start.
  task automatic do_reset();
    clk_en_i = 1'b1;
    @(negedge sys_clock_i);
    reset_n_i = 1'b0;
    @(negedge sys_clock_i);
    reset_n_i = 1'b1;
  endtask

  task automatic wait_fs(input string name, input int bound);
    int n = 0;
    while (!frame_start_o && n < bound) begin
      tick();
      n++;
    end
    check(name, frame_start_o, 1);
  endtask

  // Counts from the current frame_start character up to the next one.
  task automatic count_frame(input int bound, output int len, output int de_n,
                             output int hs_n, output int vs_n, output int vs_rise);
    logic prev_vs;
    len = 0; de_n = 0; hs_n = 0; vs_n = 0; vs_rise = -1;
    prev_vs = v_sync_o;
    do begin
      if (de_o)     de_n++;
      if (h_sync_o) hs_n++;
      if (v_sync_o) begin
        vs_n++;
        if (!prev_vs && vs_rise < 0) vs_rise = len;
      end
      prev_vs = v_sync_o;
      len++;
      tick();
    end while (!frame_start_o && len < bound);
  endtask

  initial begin
    cfg_t       c8032, csmall, cv_tmp;
    frame_vec_t fv[5];
    obs_t       cv[18];
    int         len, de_n, hs_n, vs_n, vs_rise;

    c8032  = '{8'd49, 8'd40, 8'd41, 4'd15, 5'd16, 7'd32, 5'd3, 7'd25, 7'd29, 5'd9, 14'h1000};
    csmall = '{8'd7, 8'd4, 8'd5, 4'd2, 5'd1, 7'd2, 5'd1, 7'd2, 7'd2, 5'd1, 14'h3FFE};

    fv[0] = '{"8032", c8032, 16650, 10000, 4995, 800, 14500};
    fv[1] = '{"small", csmall, 56, 16, 14, 8, 32};
    cv_tmp = csmall; cv_tmp.r5 = 5'd0;
    fv[2] = '{"small_r5_0", cv_tmp, 48, 16, 12, 8, 32};
    cv_tmp = csmall; cv_tmp.r3h = 4'd0;
    fv[3] = '{"small_r3h_0", cv_tmp, 56, 16, 0, 8, 32};
    cv_tmp = csmall; cv_tmp.r7 = 7'd5;
    fv[4] = '{"small_r7_5", cv_tmp, 56, 16, 14, 0, -1};

    // Small frame, first 18 characters after reset: lines 0 and 1 of row 0, start of row 1.
    cv[0]  = mk(1, 1, 0, 0, 14'h3FFE, 5'd0);
    cv[1]  = mk(0, 1, 0, 0, 14'h3FFF, 5'd0);
    cv[2]  = mk(0, 1, 0, 0, 14'h0000, 5'd0);
    cv[3]  = mk(0, 1, 0, 0, 14'h0001, 5'd0);
    cv[4]  = mk(0, 0, 0, 0, 14'h0002, 5'd0);
    cv[5]  = mk(0, 0, 1, 0, 14'h0003, 5'd0);
    cv[6]  = mk(0, 0, 1, 0, 14'h0004, 5'd0);
    cv[7]  = mk(0, 0, 0, 0, 14'h0005, 5'd0);
    cv[8]  = mk(0, 1, 0, 0, 14'h3FFE, 5'd1);
    cv[9]  = mk(0, 1, 0, 0, 14'h3FFF, 5'd1);
    cv[10] = mk(0, 1, 0, 0, 14'h0000, 5'd1);
    cv[11] = mk(0, 1, 0, 0, 14'h0001, 5'd1);
    cv[12] = mk(0, 0, 0, 0, 14'h0002, 5'd1);
    cv[13] = mk(0, 0, 1, 0, 14'h0003, 5'd1);
    cv[14] = mk(0, 0, 1, 0, 14'h0004, 5'd1);
    cv[15] = mk(0, 0, 0, 0, 14'h0005, 5'd1);
    cv[16] = mk(0, 1, 0, 0, 14'h0002, 5'd0);
    cv[17] = mk(0, 1, 0, 0, 14'h0003, 5'd0);

    apply_cfg(csmall);
    #3;
    check("reset_state", observe(), mk(0, 0, 0, 0, 14'h0000, 5'd0));

    do_reset();
    for (int i = 0; i < 18; i++) begin
      tick();
      check($sformatf("small_char_%0d", i), observe(), cv[i]);
    end

    for (int v = 0; v < 5; v++) begin
      apply_cfg(fv[v].cfg);
      do_reset();
      tick();
      wait_fs({fv[v].name, "_first_fs"}, 10);
      count_frame(20000, len, de_n, hs_n, vs_n, vs_rise);
      count_frame(20000, len, de_n, hs_n, vs_n, vs_rise);
      check({fv[v].name, "_len"},     len,     fv[v].len);
      check({fv[v].name, "_de"},      de_n,    fv[v].de_n);
      check({fv[v].name, "_hsync"},   hs_n,    fv[v].hs_n);
      check({fv[v].name, "_vsync"},   vs_n,    fv[v].vs_n);
      check({fv[v].name, "_vs_rise"}, vs_rise, fv[v].vs_rise);
    end

    // clk_en_i low holds every output at line 0, h=5.
    apply_cfg(csmall);
    do_reset();
    repeat (6) tick();
    clk_en_i = 1'b0;
    repeat (4) tick();
    check("hold_clk_en", observe(), mk(0, 0, 1, 0, 14'h0003, 5'd0));
    clk_en_i = 1'b1;
    tick();
    check("resume_after_hold", observe(), mk(0, 0, 1, 0, 14'h0004, 5'd0));

    // R0 dropped below h=5: the line ends next character and HSYNC survives the wrap.
    do_reset();
    repeat (6) tick();
    r0_h_total_i = 8'd3;
    tick();
    check("r0_reduce_wrap", observe(), mk(0, 1, 1, 0, 14'h3FFE, 5'd1));
    tick();
    check("r0_reduce_next", observe(), mk(0, 1, 0, 0, 14'h3FFF, 5'd1));
    r0_h_total_i = 8'd7;

    // Start address written mid-frame only takes effect at the next frame start.
    do_reset();
    repeat (3) tick();
    r1213_start_addr_i = 14'h0100;
    repeat (6) tick();
    check("sa_midframe_line1", observe(), mk(0, 1, 0, 0, 14'h3FFE, 5'd1));
    wait_fs("sa_next_fs", 100);
    check("sa_next_frame_ma", ma_o, 14'h0100);

    // Asynchronous reset mid-line, idle restart, then first enabled character.
    r1213_start_addr_i = 14'h3FFE;
    do_reset();
    repeat (14) tick();
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_reset_outputs", observe(), mk(0, 0, 0, 0, 14'h0000, 5'd0));
    clk_en_i = 1'b0;
    @(negedge sys_clock_i);
    reset_n_i = 1'b1;
    r1213_start_addr_i = 14'h1234;
    repeat (3) tick();
    check("post_reset_idle", observe(), mk(0, 0, 0, 0, 14'h0000, 5'd0));
    clk_en_i = 1'b1;
    tick();
    check("post_reset_first_char", observe(), mk(1, 1, 0, 0, 14'h1234, 5'd0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
